// File: rtl/cntry_vehicle_detector.sv
// Country-road vehicle detector: synchronises and debounces the arrival/departure
// loops, keeps a saturating waiting count and raises X while vehicles wait or the loop is stuck.

module cntry_vehicle_debounce #(
    parameter int DEB_CYC = 3
) (
    input  logic clck,
    input  logic clear,
    input  logic raw,
    output logic level
);
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

    logic          s1;
    logic          s2;
    logic [DW-1:0] stab_cnt;

    always_ff @(posedge clck) begin
        if (clear) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            level    <= 1'b0;
            stab_cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                stab_cnt <= '0;
            end else if (stab_cnt == DEB_LAST) begin
                // disagreement held for DEB_CYC cycles: accept the new level
                level    <= s2;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end
endmodule

module cntry_vehicle_detector #(
    parameter int DEB_CYC   = 3,
    parameter int CNT_W     = 4,
    parameter int STUCK_CYC = 200
) (
    input  logic             clck,
    input  logic             clear,
    input  logic             arr_raw,
    input  logic             dep_raw,
    input  logic [1:0]       cntry,
    output logic             X,
    output logic [CNT_W-1:0] waiting,
    output logic             fault,
    output logic             ovf
);
    localparam int SW = (STUCK_CYC > 1) ? $clog2(STUCK_CYC + 1) : 1;
    localparam logic [SW-1:0]    STUCK_TC = SW'(STUCK_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [1:0]       LAMP_RED = 2'b11;

    logic             arr_lvl;
    logic             dep_lvl;
    logic             arr_lvl_d;
    logic             dep_lvl_d;
    logic             arr_pulse;
    logic             dep_pulse;
    logic [SW-1:0]    stuck_cnt;
    logic [SW-1:0]    stuck_nxt;
    logic [CNT_W-1:0] waiting_nxt;
    logic             ovf_nxt;

    cntry_vehicle_debounce #(.DEB_CYC(DEB_CYC)) u_arr_deb (
        .clck  (clck),
        .clear (clear),
        .raw   (arr_raw),
        .level (arr_lvl)
    );

    cntry_vehicle_debounce #(.DEB_CYC(DEB_CYC)) u_dep_deb (
        .clck  (clck),
        .clear (clear),
        .raw   (dep_raw),
        .level (dep_lvl)
    );

    // departures only credit a vehicle while the country lamp is not Red
    assign arr_pulse = arr_lvl & ~arr_lvl_d;
    assign dep_pulse = dep_lvl & ~dep_lvl_d & (cntry != LAMP_RED);

    always_comb begin
        waiting_nxt = waiting;
        ovf_nxt     = ovf;
        if (arr_pulse && !dep_pulse) begin
            if (waiting == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                waiting_nxt = waiting + 1'b1;
            end
        end else if (dep_pulse && !arr_pulse && (waiting != '0)) begin
            waiting_nxt = waiting - 1'b1;
        end
    end

    always_comb begin
        stuck_nxt = stuck_cnt;
        if (!arr_lvl) begin
            stuck_nxt = '0;
        end else if (stuck_cnt != STUCK_TC) begin
            stuck_nxt = stuck_cnt + 1'b1;
        end
    end

    always_ff @(posedge clck) begin
        if (clear) begin
            arr_lvl_d <= 1'b0;
            dep_lvl_d <= 1'b0;
            waiting   <= '0;
            ovf       <= 1'b0;
            stuck_cnt <= '0;
            X         <= 1'b0;
        end else begin
            arr_lvl_d <= arr_lvl;
            dep_lvl_d <= dep_lvl;
            waiting   <= waiting_nxt;
            ovf       <= ovf_nxt;
            stuck_cnt <= stuck_nxt;
            // built from next-state values so X moves on the same edge as waiting/fault
            X         <= (waiting_nxt != '0) | (stuck_nxt == STUCK_TC);
        end
    end

    assign fault = (stuck_cnt == STUCK_TC);
endmodule

// File: doc/cntry_vehicle_detector.md
# cntry_vehicle_detector

Front-end stage that produces the `X` vehicle-present request consumed by the highway/country traffic signal controller. It synchronises and debounces two raw country-road loop sensors: an arrival loop before the stop line and a departure loop past it. It keeps a saturating count of waiting vehicles, crediting departures only while the country road is not Red. It drives `X` high while any vehicle waits, or while the arrival loop is judged stuck (fail-safe).

## Interface
- `DEB_CYC`, 3: consecutive synchronised cycles a sensor level must hold before the debounced level changes (≥1).
- `CNT_W`, 4: width of the waiting-vehicle counter; maximum count is 2^CNT_W−1.
- `STUCK_CYC`, 200: cycles the debounced arrival level may stay high before `fault` asserts (≥1).

Ports (clock and reset first):
- `clck`, in, 1: single clock; all state changes on its rising edge.
- `clear`, in, 1: synchronous, active-high reset; dominates every other input.
- `arr_raw`, in, 1: raw arrival loop, asynchronous; 1 = metal present.
- `dep_raw`, in, 1: raw departure loop, asynchronous; 1 = metal present.
- `cntry`, in, 2: country lamp state from the controller: 00 Green, 10 Yellow, 11 Red.
- `X`, out, 1: registered request to the controller.
- `waiting`, out, CNT_W: registered count of waiting vehicles.
- `fault`, out, 1: arrival loop stuck high.
- `ovf`, out, 1: sticky flag; an arrival was lost to saturation.

## Operation
- Each raw input passes through a 2-flop synchroniser (`s1`, `s2`).
- Each sensor has a debouncer: a debounced level register plus a stability counter.
  - The counter increments while `s2` ≠ the debounced level.
  - The counter resets to 0 on any cycle where `s2` equals the debounced level.
  - On reaching `DEB_CYC`, the debounced level takes `s2` and the counter resets.
- Pulse generation:
  - Arrival pulse: debounced arrival 0→1, one cycle.
  - Departure pulse: debounced departure 0→1 while `cntry` ≠ 11, sampled in the same cycle. Departure edges during Red are discarded.
- Counter update, registered, exactly one rule per cycle:
  - Arrival and departure together: count unchanged.
  - Arrival only: +1. At 2^CNT_W−1 the count holds and `ovf` sets.
  - Departure only: −1. At 0 the count holds and nothing else happens.
- Fault:
  - A stuck counter increments each cycle the debounced arrival level is 1, saturating at `STUCK_CYC`.
  - It clears to 0 when the debounced arrival level is 0.
  - `fault` = 1 while the stuck counter equals `STUCK_CYC`. It deasserts on the cycle after the debounced arrival level returns to 0.
- `X` is registered: `X` = (next `waiting` ≠ 0) | next `fault`. `X` changes on the same edge as `waiting` and `fault`.
- `ovf` stays set until `clear`.
- Reset: every flop goes to 0, so `X`=0, `waiting`=0, `fault`=0, `ovf`=0. An in-progress debounce, count or stuck timing is discarded.

## Timing
- Raw edge present before edge 0:
  - `s1` updates at edge 0, `s2` at edge 1.
  - The debounced level changes at edge 1+`DEB_CYC`.
  - `waiting` and `X` update at edge 2+`DEB_CYC`. With defaults this is edge 5.
- A glitch shorter than `DEB_CYC` synchronised cycles produces no pulse and no count change.
- `fault` asserts at edge 1+`DEB_CYC`+`STUCK_CYC` for a continuous high arrival level.
- `cntry` is used unsynchronised; it is in the same clock domain, driven by the controller.
- `clear` high at any edge forces reset values at that edge, regardless of pulses in flight.
- No handshake: `X` is a level. The controller samples it every cycle.

## Test plan
- Reset: `clear`=1 for 2 cycles with `arr_raw`=1 → `X`=0, `waiting`=0, `fault`=0, `ovf`=0. After release, `waiting`=1 and `X`=1 at edge 5 after the release edge.
- Glitch rejection: `arr_raw` high for 2 cycles, then low → `waiting` stays 0 and `X` stays 0. A 4-cycle pulse → `waiting`=1 at edge 5.
- Red gating: 3 arrivals, then a `dep_raw` pulse with `cntry`=11 → `waiting`=3. The same pulse with `cntry`=00 → 2. Two more departures → 0, and `X` falls on the edge where `waiting` reaches 0.
- Simultaneous events: arrival and departure debounced edges in the same cycle at `waiting`=2 with `cntry`=10 → `waiting`=2. A departure at `waiting`=0 → it stays 0 with no underflow.
- Saturation: 16 arrivals with `CNT_W`=4 → `waiting`=15 and `ovf`=1. A following departure → 14 with `ovf` still 1. `clear` → `ovf`=0.
- Stuck sensor: `arr_raw` held high 210 cycles → `fault`=1 and `X`=1 from edge 204, even after departures drain `waiting` to 0. Drop `arr_raw` → `fault`=0 on the cycle after the debounced level falls, and `X` follows `waiting`.
